traffic_signal_controller: RTL
==============================

TRAFFIC_SIGNAL_CONTROLLER -- requirements
Module: traffic_signal_controller

Interface
REQ-001 SHALL have parameter NUM_DIRS, default 4, number of approaches (legal 2..8).
REQ-002 SHALL have parameter GREEN_CYCLES, default 8, minimum green length in clocks (>=1).
REQ-003 SHALL have parameter YELLOW_CYCLES, default 3, exact yellow length in clocks (>=1).
REQ-004 SHALL have parameter ALLRED_CYCLES, default 1, exact all-red clearance length in clocks (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port request  input  NUM_DIRS  per-approach vehicle sensor, bit i = approach i.
REQ-008 SHALL have port emergency  input  1  level; forces all approaches red while high.
REQ-009 SHALL have port lights  output  2*NUM_DIRS  light code of approach i in bits [2i+1:2i].
REQ-010 SHALL have port active_dir  output  clog2(NUM_DIRS)  approach currently owning or last owning the green.
REQ-011 SHALL have port pending  output  NUM_DIRS  latched unserved requests.

Function
REQ-012 SHALL encode lights as green 00, yellow 01, red 10; code 11 is never driven.
REQ-013 SHALL implement states GREEN, YELLOW, ALLRED, EMERGENCY; all outputs registered.
REQ-014 SHALL keep a phase counter that clears on every state entry and increments once per clock.
REQ-015 SHALL set pending[i] on any cycle request[i]=1, except when i is active_dir in GREEN; pending[i] clears on the cycle approach i enters GREEN.
REQ-016 GREEN: active_dir shows 00, all others 10; leaves to YELLOW when counter >= GREEN_CYCLES-1 and any other pending bit is set; otherwise holds green indefinitely.
REQ-017 YELLOW: active_dir shows 01, others 10; lasts exactly YELLOW_CYCLES clocks, then ALLRED.
REQ-018 ALLRED: all approaches 10 for exactly ALLRED_CYCLES clocks, then GREEN for the winner.
REQ-019 Winner SHALL be the first pending approach scanning active_dir+1, active_dir+2, ... modulo NUM_DIRS (round-robin, wraps NUM_DIRS-1 -> 0); if none pending, winner = active_dir.
REQ-020 emergency=1 in any state SHALL enter EMERGENCY next clock: all approaches 10; pending keeps latching; counter held at 0.
REQ-021 On emergency deassert SHALL enter ALLRED (full ALLRED_CYCLES), then GREEN per REQ-019.
REQ-022 Simultaneous emergency and phase-end transition: emergency wins.
REQ-023 active_dir SHALL update on the same clock the winner enters GREEN.

Reset
REQ-024 reset=1 SHALL on the next clock edge set state GREEN, active_dir 0, counter 0, pending all 0, lights = approach 0 at 00, all others 10.
REQ-025 reset SHALL take priority over emergency and request, including mid-YELLOW/ALLRED.

Structure
REQ-026 Light codes (GREEN/YELLOW/RED) and the state enum SHALL live in shared package traffic_pkg, reused by the driver FSM.
REQ-027 Round-robin winner selection SHALL be sub-module rr_next_dir (inputs pending, active_dir; output winner, any_pending).
REQ-028 Counter width SHALL be derived as clog2 of the largest of the three cycle parameters plus 1.

Verification (defaults: 4 dirs, G=8, Y=3, AR=1)
REQ-029 Reset, no requests for 50 clocks -> lights = 10_10_10_00 throughout, active_dir 0.
REQ-030 1-cycle pulse request[2] at clock 2 after reset -> dir0 green clocks 0-7, yellow 8-10, all red 11, dir2 green from 12, pending[2] clears at 12.
REQ-031 request[1] and request[3] together during dir0 green -> served 1 then 3; from dir3 green, request[0] -> wraps to dir0.
REQ-032 emergency high mid-YELLOW for 5 clocks -> all 10 next clock through deassert, then 1 all-red clock, then winner green.
REQ-033 reset pulse mid-YELLOW with pending=0110 -> next clock dir0 green, pending 0000.
REQ-034 request[active_dir] during its own green -> pending stays 0, green held indefinitely.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light codes, controller state encoding and a small sizing helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    StGreen,
    StYellow,
    StAllred,
    StEmergency
  } state_e;

  localparam logic [1:0] LightGreen  = 2'b00;
  localparam logic [1:0] LightYellow = 2'b01;
  localparam logic [1:0] LightRed    = 2'b10;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin pick of the next approach to receive green.
module rr_next_dir
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIRS = 4,
  localparam int unsigned DirW    = $clog2(NUM_DIRS)
) (
  input  logic [NUM_DIRS-1:0] pending,
  input  logic [DirW-1:0]     active_dir,
  output logic [DirW-1:0]     winner,
  output logic                any_pending
);

  // Scan active_dir+1 .. active_dir+NUM_DIRS; the last slot is active_dir itself.
  always_comb begin
    logic found;
    found       = 1'b0;
    winner      = active_dir;
    any_pending = |pending;
    for (int k = 1; k <= int'(NUM_DIRS); k++) begin
      logic [DirW-1:0] idx;
      idx = DirW'((int'(active_dir) + k) % int'(NUM_DIRS));
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_signal_controller.sv
// Multi-approach traffic signal controller with round-robin service and emergency override.
module traffic_signal_controller
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIRS      = 4,
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 1,
  localparam int unsigned DirW         = $clog2(NUM_DIRS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIRS-1:0]   request,
  input  logic                  emergency,
  output logic [2*NUM_DIRS-1:0] lights,
  output logic [DirW-1:0]       active_dir,
  output logic [NUM_DIRS-1:0]   pending
);

  localparam int unsigned CntW = $clog2(max3(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES)) + 1;

  localparam logic [CntW-1:0] GreenLast  = CntW'(GREEN_CYCLES - 1);
  localparam logic [CntW-1:0] YellowLast = CntW'(YELLOW_CYCLES - 1);
  localparam logic [CntW-1:0] AllredLast = CntW'(ALLRED_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};

  localparam logic [2*NUM_DIRS-1:0] LightsRst = {{(NUM_DIRS - 1){LightRed}}, LightGreen};

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DirW-1:0]       active_q, active_d;
  logic [NUM_DIRS-1:0]   pending_q, pending_d;
  logic [2*NUM_DIRS-1:0] lights_q, lights_d;

  logic [DirW-1:0]       winner;
  logic                  any_pending;
  logic                  enter_green;

  rr_next_dir #(
    .NUM_DIRS(NUM_DIRS)
  ) u_rr_next_dir (
    .pending    (pending_q),
    .active_dir (active_q),
    .winner     (winner),
    .any_pending(any_pending)
  );

  // Next phase: emergency overrides any phase-end transition.
  always_comb begin
    state_d = state_q;
    if (emergency) begin
      state_d = StEmergency;
    end else begin
      case (state_q)
        StGreen: begin
          // Own bit is never pending while green, so any_pending means another approach waits.
          if (cnt_q >= GreenLast && any_pending) state_d = StYellow;
        end
        StYellow:    if (cnt_q >= YellowLast) state_d = StAllred;
        StAllred:    if (cnt_q >= AllredLast) state_d = StGreen;
        StEmergency: state_d = StAllred;
        default:     state_d = StGreen;
      endcase
    end
  end

  // Phase counter, owner, request latches and registered light codes.
  always_comb begin
    enter_green = (state_q != StGreen) && (state_d == StGreen);

    // Counter saturates so an indefinitely held green never wraps.
    if (state_d != state_q || state_d == StEmergency) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    active_d = enter_green ? winner : active_q;

    pending_d = pending_q;
    for (int i = 0; i < int'(NUM_DIRS); i++) begin
      if (request[i] && !(state_q == StGreen && DirW'(i) == active_q)) pending_d[i] = 1'b1;
      if (enter_green && DirW'(i) == winner) pending_d[i] = 1'b0;
    end

    lights_d = '0;
    for (int i = 0; i < int'(NUM_DIRS); i++) begin
      lights_d[2*i +: 2] = LightRed;
      if (DirW'(i) == active_d) begin
        if (state_d == StGreen)  lights_d[2*i +: 2] = LightGreen;
        if (state_d == StYellow) lights_d[2*i +: 2] = LightYellow;
      end
    end
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StGreen;
      cnt_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      lights_q  <= LightsRst;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      lights_q  <= lights_d;
    end
  end

  assign lights     = lights_q;
  assign active_dir = active_q;
  assign pending    = pending_q;

endmodule
